// File: rtl/multicycle_ctrl_fsm_v2.sv
// Multicycle control FSM for the 8-bit accumulator CPU: fetch/decode/execute/writeback
// with MemReady handshake, bus-error timeout, STOP, illegal-opcode flag. Optional macro: STEP_EN.
module multicycle_ctrl_fsm_v2 #(
  parameter int OPW      = 8,
  parameter int ALUOP_W  = 3,
  parameter int ALUB_W   = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic               CLOCK_50,
  input  logic               Reset,
  input  logic [OPW-1:0]     OpCode,
  input  logic               N,
  input  logic               Z,
  input  logic               MemReady,
  input  logic               Step,
  input  logic               StepMode,
  output logic               PCwrite,
  output logic               AddrSel,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRload,
  output logic               MDRload,
  output logic               RASel,
  output logic               RFWrite,
  output logic               RegIn,
  output logic               ABLD,
  output logic               ALU_A,
  output logic               FlagWrite,
  output logic               ALUoutLD,
  output logic [ALUB_W-1:0]  ALU_B,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               Halted,
  output logic               BusErr,
  output logic               Illegal,
  output logic [3:0]         StateOut
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC    = 4'd2,
    S_WB      = 4'd3,
    S_ORI_RA  = 4'd4,
    S_ORI_ALU = 4'd5,
    S_HALT    = 4'd7
  } state_t;

  state_t     state, state_next;
  logic [7:0] wait_cnt;
  logic [2:0] b_sel, op_sel;
  logic       fetch_active, mem_access, mem_wait, timeout;

  logic [3:0] ins;
  logic is_add, is_sub, is_nand, is_load, is_store, is_bnz, is_bpz, is_bz;
  logic is_stop, is_ori, is_shift, is_branch, is_illegal;

  assign ins       = OpCode[3:0];
  assign is_add    = (ins == 4'b0100);
  assign is_sub    = (ins == 4'b0110);
  assign is_nand   = (ins == 4'b1000);
  assign is_load   = (ins == 4'b0000);
  assign is_store  = (ins == 4'b0010);
  assign is_bnz    = (ins == 4'b0101);
  assign is_bpz    = (ins == 4'b1001);
  assign is_bz     = (ins == 4'b1010);
  assign is_stop   = (ins == 4'b0001);
  assign is_ori    = (ins[2:0] == 3'b111);
  assign is_shift  = (ins[2:0] == 3'b011);
  assign is_branch = is_bnz | is_bpz | is_bz;
  assign is_illegal = !(is_add | is_sub | is_nand | is_load | is_store | is_branch |
                        is_stop | is_ori | is_shift);

`ifdef STEP_EN
  // Armed by a Step pulse in FETCH; keeps a stalled fetch going until MemReady.
  logic fetch_go;
  assign fetch_active = !StepMode || Step || fetch_go;

  always_ff @(posedge CLOCK_50) begin
    if (Reset) fetch_go <= 1'b0;
    else       fetch_go <= (state == S_FETCH) && fetch_active && !MemReady && !timeout;
  end

  logic unused_ok;
  assign unused_ok = ^OpCode[OPW-1:4];
`else
  assign fetch_active = 1'b1;

  logic unused_ok;
  assign unused_ok = ^{OpCode[OPW-1:4], Step, StepMode};
`endif

  assign mem_access = ((state == S_FETCH) && fetch_active) ||
                      ((state == S_EXEC) && (is_load || is_store));
  assign mem_wait   = mem_access && !MemReady && !Reset;
  // A response arriving on the cycle the count hits WAIT_MAX still completes normally.
  assign timeout    = mem_wait && (wait_cnt == 8'(WAIT_MAX));

  // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= (mem_wait && !timeout) ? wait_cnt + 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      Halted  <= 1'b0;
      BusErr  <= 1'b0;
      Illegal <= 1'b0;
    end else begin
      if (state_next == S_HALT)                 Halted  <= 1'b1;
      if (timeout)                              BusErr  <= 1'b1;
      if ((state == S_DECODE) && is_illegal)    Illegal <= 1'b1;
    end
  end

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_next = state;
    PCwrite    = 1'b0;
    AddrSel    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRload     = 1'b0;
    MDRload    = 1'b0;
    RASel      = 1'b0;
    RFWrite    = 1'b0;
    RegIn      = 1'b0;
    ABLD       = 1'b0;
    ALU_A      = 1'b0;
    FlagWrite  = 1'b0;
    ALUoutLD   = 1'b0;
    b_sel      = 3'd0;
    op_sel     = 3'd0;

    if (!Reset) begin
      unique case (state)
        S_FETCH: begin
          if (fetch_active) begin
            AddrSel = 1'b1;
            MemRead = 1'b1;
            if (MemReady) begin
              IRload     = 1'b1;
              PCwrite    = 1'b1;
              b_sel      = 3'd1;
              state_next = S_DECODE;
            end
          end
        end
        S_DECODE: begin
          ABLD = 1'b1;
          if (is_stop)         state_next = S_HALT;
          else if (is_illegal) state_next = S_FETCH;
          else if (is_ori)     state_next = S_ORI_RA;
          else                 state_next = S_EXEC;
        end
        S_EXEC: begin
          if (is_load) begin
            MemRead = 1'b1;
            if (MemReady) begin
              MDRload    = 1'b1;
              state_next = S_WB;
            end
          end else if (is_store) begin
            MemWrite = 1'b1;
            if (MemReady) state_next = S_FETCH;
          end else if (is_branch) begin
            b_sel      = 3'd2;
            PCwrite    = is_bz ? Z : (is_bnz ? !Z : !N);
            state_next = S_FETCH;
          end else if (is_add || is_sub || is_nand || is_shift) begin
            ALU_A      = 1'b1;
            ALUoutLD   = 1'b1;
            FlagWrite  = 1'b1;
            b_sel      = is_shift ? 3'd4 : 3'd0;
            op_sel     = is_sub  ? 3'd1 :
                         is_nand ? 3'd3 :
                         is_shift ? (OpCode[5] ? 3'd4 : 3'd5) : 3'd0;
            state_next = S_WB;
          end else begin
            state_next = S_FETCH;
          end
        end
        S_WB: begin
          RFWrite    = 1'b1;
          RegIn      = is_load;
          state_next = S_FETCH;
        end
        S_ORI_RA: begin
          RASel      = 1'b1;
          ABLD       = 1'b1;
          state_next = S_ORI_ALU;
        end
        S_ORI_ALU: begin
          ALU_A      = 1'b1;
          ALUoutLD   = 1'b1;
          FlagWrite  = 1'b1;
          b_sel      = 3'd3;
          op_sel     = 3'd2;
          state_next = S_WB;
        end
        S_HALT:  state_next = S_HALT;
        default: state_next = S_FETCH;
      endcase

      if (timeout) state_next = S_HALT;
    end
  end

  assign ALU_B    = ALUB_W'(b_sel);
  assign ALUop    = ALUOP_W'(op_sel);
  assign StateOut = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm_v2.sv
// Directed bench for multicycle_ctrl_fsm_v2: per-cycle expected controls go through a
// scoreboard queue and are checked with immediate assertions. Define STEP_EN to cover stepping.
module tb_multicycle_ctrl_fsm_v2;

  logic       CLOCK_50 = 1'b0;
  logic       Reset = 1'b1, MemReady = 1'b0, N = 1'b0, Z = 1'b0, Step = 1'b0, StepMode = 1'b0;
  logic [7:0] OpCode = 8'h00;
  logic PCwrite, AddrSel, MemRead, MemWrite, IRload, MDRload, RASel, RFWrite, RegIn;
  logic ABLD, ALU_A, FlagWrite, ALUoutLD, Halted, BusErr, Illegal;
  logic [2:0] ALU_B, ALUop;
  logic [3:0] StateOut;

  multicycle_ctrl_fsm_v2 dut (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .OpCode(OpCode), .N(N), .Z(Z),
    .MemReady(MemReady), .Step(Step), .StepMode(StepMode),
    .PCwrite(PCwrite), .AddrSel(AddrSel), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRload(IRload), .MDRload(MDRload), .RASel(RASel), .RFWrite(RFWrite), .RegIn(RegIn),
    .ABLD(ABLD), .ALU_A(ALU_A), .FlagWrite(FlagWrite), .ALUoutLD(ALUoutLD),
    .ALU_B(ALU_B), .ALUop(ALUop), .Halted(Halted), .BusErr(BusErr), .Illegal(Illegal),
    .StateOut(StateOut)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [3:0]  st;
    logic [12:0] ctl;
    logic [2:0]  alub;
    logic [2:0]  aluop;
    logic        halted;
    logic        buserr;
    logic        illegal;
  } exp_t;

  localparam logic [12:0] C_PCW  = 13'h1000;
  localparam logic [12:0] C_ADS  = 13'h0800;
  localparam logic [12:0] C_MRD  = 13'h0400;
  localparam logic [12:0] C_MWR  = 13'h0200;
  localparam logic [12:0] C_IRL  = 13'h0100;
  localparam logic [12:0] C_MDRL = 13'h0080;
  localparam logic [12:0] C_RAS  = 13'h0040;
  localparam logic [12:0] C_RFW  = 13'h0020;
  localparam logic [12:0] C_RGI  = 13'h0010;
  localparam logic [12:0] C_ABL  = 13'h0008;
  localparam logic [12:0] C_ALA  = 13'h0004;
  localparam logic [12:0] C_FLW  = 13'h0002;
  localparam logic [12:0] C_AOL  = 13'h0001;
  localparam logic [12:0] C_FETCH_OK = C_PCW | C_ADS | C_MRD | C_IRL;
  localparam logic [12:0] C_ALU      = C_ALA | C_FLW | C_AOL;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  logic h_exp = 1'b0, be_exp = 1'b0, il_exp = 1'b0;

  function automatic exp_t observe();
    exp_t o;
    o.st      = StateOut;
    o.ctl     = {PCwrite, AddrSel, MemRead, MemWrite, IRload, MDRload, RASel,
                 RFWrite, RegIn, ABLD, ALU_A, FlagWrite, ALUoutLD};
    o.alub    = ALU_B;
    o.aluop   = ALUop;
    o.halted  = Halted;
    o.buserr  = BusErr;
    o.illegal = Illegal;
    return o;
  endfunction

  task automatic check(input string tag);
    exp_t e, o;
    e = sb_q.pop_front();
    o = observe();
    n_checks++;
    assert (o === e) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h (st/ctl/alub/aluop/H/B/I)", tag, o, e);
    end
  endtask

  // One clock cycle: apply inputs at the falling edge, queue expectation, sample 1 unit later.
  task automatic cyc(input logic rst, input logic mr, input logic [7:0] op, input logic n,
                     input logic z, input logic [3:0] st, input logic [12:0] ctl,
                     input logic [2:0] b, input logic [2:0] aop, input string tag);
    Reset = rst; MemReady = mr; OpCode = op; N = n; Z = z;
    sb_q.push_back('{st: st, ctl: ctl, alub: b, aluop: aop,
                     halted: h_exp, buserr: be_exp, illegal: il_exp});
    #1;
    check(tag);
    @(negedge CLOCK_50);
  endtask

  task automatic fetch_decode(input logic [7:0] op, input logic n, input logic z, input string tag);
    cyc(1'b0, 1'b1, op, n, z, 4'd0, C_FETCH_OK, 3'd1, 3'd0, {tag, "_fetch"});
    cyc(1'b0, 1'b1, op, n, z, 4'd1, C_ABL,      3'd0, 3'd0, {tag, "_decode"});
  endtask

  task automatic run_alu(input logic [7:0] op, input logic [2:0] b, input logic [2:0] aop,
                         input string tag);
    fetch_decode(op, 1'b0, 1'b0, tag);
    cyc(1'b0, 1'b1, op, 1'b0, 1'b0, 4'd2, C_ALU, b, aop,       {tag, "_exec"});
    cyc(1'b0, 1'b1, op, 1'b0, 1'b0, 4'd3, C_RFW, 3'd0, 3'd0,   {tag, "_wb"});
  endtask

  task automatic run_branch(input logic [7:0] op, input logic n, input logic z,
                            input logic take, input string tag);
    fetch_decode(op, n, z, tag);
    cyc(1'b0, 1'b1, op, n, z, 4'd2, take ? C_PCW : 13'h0, 3'd2, 3'd0, {tag, "_exec"});
  endtask

  initial begin
    @(negedge CLOCK_50);
    // Reset held with MemReady=1: fetch controls must stay forced low.
    cyc(1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 4'd0, 13'h0, 3'd0, 3'd0, "reset_state");

    run_alu(8'h04, 3'd0, 3'd0, "add");
    run_alu(8'h06, 3'd0, 3'd1, "sub");
    run_alu(8'h08, 3'd0, 3'd3, "nand");
    run_alu(8'h23, 3'd4, 3'd4, "shl");
    run_alu(8'h0B, 3'd4, 3'd5, "shr");

    fetch_decode(8'hA7, 1'b0, 1'b0, "ori");
    cyc(1'b0, 1'b1, 8'hA7, 1'b0, 1'b0, 4'd4, C_RAS | C_ABL, 3'd0, 3'd0, "ori_ra");
    cyc(1'b0, 1'b1, 8'hA7, 1'b0, 1'b0, 4'd5, C_ALU,         3'd3, 3'd2, "ori_alu");
    cyc(1'b0, 1'b1, 8'hA7, 1'b0, 1'b0, 4'd3, C_RFW,         3'd0, 3'd0, "ori_wb");

    fetch_decode(8'h00, 1'b0, 1'b0, "load");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd2, C_MRD, 3'd0, 3'd0, "load_wait");
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd2, C_MRD | C_MDRL, 3'd0, 3'd0, "load_done");
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd3, C_RFW | C_RGI,  3'd0, 3'd0, "load_wb");

    // MemReady arrives exactly when the wait count has reached WAIT_MAX: no bus error.
    fetch_decode(8'h00, 1'b0, 1'b0, "load15");
    for (int i = 0; i < 15; i++)
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd2, C_MRD, 3'd0, 3'd0, "load15_wait");
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd2, C_MRD | C_MDRL, 3'd0, 3'd0, "load15_edge_done");
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd3, C_RFW | C_RGI,  3'd0, 3'd0, "load15_wb");

    fetch_decode(8'h02, 1'b0, 1'b0, "store");
    cyc(1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 4'd2, C_MWR, 3'd0, 3'd0, "store_exec");

    run_branch(8'h0A, 1'b0, 1'b1, 1'b1, "bz_z1");
    run_branch(8'h0A, 1'b0, 1'b0, 1'b0, "bz_z0");
    run_branch(8'h05, 1'b0, 1'b1, 1'b0, "bnz_z1");
    run_branch(8'h09, 1'b0, 1'b0, 1'b1, "bpz_n0");
    run_branch(8'h09, 1'b1, 1'b0, 1'b0, "bpz_n1");

    // Illegal opcode: two cycles, then a normal instruction with the flag now set.
    fetch_decode(8'h0C, 1'b0, 1'b0, "illegal");
    il_exp = 1'b1;
    run_alu(8'h04, 3'd0, 3'd0, "post_illegal_add");

    // Reset in the middle of a stalled store.
    fetch_decode(8'h02, 1'b0, 1'b0, "store_rst");
    for (int i = 0; i < 2; i++)
      cyc(1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 4'd2, C_MWR, 3'd0, 3'd0, "store_rst_wait");
    cyc(1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 4'd2, 13'h0, 3'd0, 3'd0, "store_rst_cycle");
    il_exp = 1'b0;

    // Fetch with MemReady stuck low: 16 fetch cycles, the last with the count at WAIT_MAX.
    for (int i = 0; i < 16; i++)
      cyc(1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 4'd0, C_ADS | C_MRD, 3'd0, 3'd0, "timeout_fetch");
    h_exp = 1'b1; be_exp = 1'b1;
    cyc(1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 4'd7, 13'h0, 3'd0, 3'd0, "timeout_halt");
    cyc(1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 4'd7, 13'h0, 3'd0, 3'd0, "timeout_halt_hold");
    cyc(1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 4'd7, 13'h0, 3'd0, 3'd0, "timeout_reset_cycle");
    h_exp = 1'b0; be_exp = 1'b0;

    fetch_decode(8'h01, 1'b0, 1'b0, "stop");
    h_exp = 1'b1;
    cyc(1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 4'd7, 13'h0, 3'd0, 3'd0, "stop_halt");
    cyc(1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 4'd7, 13'h0, 3'd0, 3'd0, "stop_halt_hold");
    cyc(1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 4'd7, 13'h0, 3'd0, 3'd0, "stop_reset_cycle");
    h_exp = 1'b0;
    cyc(1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 4'd0, C_FETCH_OK, 3'd1, 3'd0, "restart_fetch");

`ifdef STEP_EN
    cyc(1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 4'd1, C_ABL, 3'd0, 3'd0, "restart_decode");
    cyc(1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 4'd2, C_ALU, 3'd0, 3'd0, "restart_exec");
    cyc(1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 4'd3, C_RFW, 3'd0, 3'd0, "restart_wb");
    StepMode = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 4'd0, 13'h0, 3'd0, 3'd0, "step_idle");
    Step = 1'b1;
    cyc(1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 4'd0, C_FETCH_OK, 3'd1, 3'd0, "step_fetch");
    Step = 1'b0;
    cyc(1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 4'd1, C_ABL, 3'd0, 3'd0, "step_decode");
    cyc(1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 4'd2, C_ALU, 3'd0, 3'd0, "step_exec");
    cyc(1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 4'd3, C_RFW, 3'd0, 3'd0, "step_wb");
    cyc(1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 4'd0, 13'h0, 3'd0, 3'd0, "step_idle_again");
    StepMode = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
